// File: rtl/alarm_pkg.sv
// Shared state encodings and constants for the alarm trigger slice.
package alarm_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RINGING = 2'd2,
      SNOOZE  = 2'd3
   } state_t;

   localparam int BCD_W = 16;
   localparam logic [BCD_W-1:0] LED_ON = 16'hFFFF;
endpackage

// File: rtl/sec_countdown.sv
// Loadable 8-bit seconds down-counter; done pulses on the tick that leaves 1.
module sec_countdown (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       tick,
   output logic       done
);
   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (tick && count != 8'd0)
         count <= count - 8'd1;
   end

   assign done = tick && (count == 8'd1);
endmodule

// File: rtl/alarm_trigger.sv
// Alarm match detection plus ring/snooze/dismiss state machine driving
// the buzzer enable and LED bank.
module alarm_trigger
   import alarm_pkg::*;
#(
   parameter int RING_SECS   = 30,
   parameter int SNOOZE_SECS = 10,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sec_tick,
   input  logic [BCD_W-1:0] time_now,
   input  logic [BCD_W-1:0] alarm,
   input  logic             alarm_en,
   input  logic             set_mode,
   input  logic             push_c,
   input  logic             push_u,
   output logic             ringing,
   output logic [BCD_W-1:0] led,
   output logic             missed,
   output logic [1:0]       state
);
   localparam logic [7:0] RING_LD   = 8'(RING_SECS);
   localparam logic [7:0] SNOOZE_LD = 8'(SNOOZE_SECS);
   localparam logic [2:0] MAX_SNZ   = 3'(MAX_SNOOZE);

   state_t     st;
   logic       match;
   logic       match_q;
   logic       fire;
   logic       dismiss;
   logic       blink;
   logic [2:0] snz_cnt;
   logic       cnt_load;
   logic [7:0] cnt_val;
   logic       cnt_done;

   function automatic logic [BCD_W-1:0] led_pattern(input state_t s, input logic b,
                                                    input logic [2:0] n);
      logic [BCD_W-1:0] p;
      p = '0;
      if (s == RINGING) begin
         p = b ? LED_ON : '0;
      end else if (s == SNOOZE) begin
         if (n >= 3'd3)
            p[2:0] = 3'b111;
         else if (n == 3'd2)
            p[2:0] = 3'b011;
         else if (n == 3'd1)
            p[2:0] = 3'b001;
      end
      return p;
   endfunction

   // Edge-qualified match: one fire per entry into the matching time.
   assign match   = (time_now == alarm);
   assign fire    = match && !match_q && !set_mode;
   assign dismiss = push_c || set_mode;
   assign state   = st;

   // The shared timer reloads on entry to RINGING (ring length) or SNOOZE.
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = RING_LD;
      case (st)
         ARMED:   cnt_load = alarm_en && fire;
         RINGING: begin
            if (alarm_en && !dismiss && push_u && snz_cnt < MAX_SNZ) begin
               cnt_load = 1'b1;
               cnt_val  = SNOOZE_LD;
            end
         end
         SNOOZE:  cnt_load = alarm_en && !dismiss && cnt_done;
         default: cnt_load = 1'b0;
      endcase
   end

   sec_countdown u_countdown (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .tick     (sec_tick),
      .done     (cnt_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st      <= IDLE;
         match_q <= 1'b0;
         blink   <= 1'b0;
         snz_cnt <= '0;
         missed  <= 1'b0;
         ringing <= 1'b0;
         led     <= '0;
      end else begin
         match_q <= match;
         ringing <= (st == RINGING);
         led     <= led_pattern(st, blink, snz_cnt);
         if (push_c)
            missed <= 1'b0;

         case (st)
            IDLE: begin
               if (alarm_en)
                  st <= ARMED;
            end
            ARMED: begin
               if (!alarm_en) begin
                  st <= IDLE;
               end else if (fire) begin
                  st      <= RINGING;
                  blink   <= 1'b1;
                  snz_cnt <= '0;
               end
            end
            RINGING: begin
               if (!alarm_en) begin
                  st <= IDLE;
               end else if (dismiss) begin
                  st     <= ARMED;
                  missed <= 1'b0;
               end else if (push_u && snz_cnt < MAX_SNZ) begin
                  st      <= SNOOZE;
                  snz_cnt <= snz_cnt + 3'd1;
               end else if (cnt_done) begin
                  st     <= ARMED;
                  missed <= 1'b1;
               end else if (sec_tick) begin
                  blink <= !blink;
               end
            end
            SNOOZE: begin
               if (!alarm_en) begin
                  st <= IDLE;
               end else if (dismiss) begin
                  st <= ARMED;
               end else if (cnt_done) begin
                  st    <= RINGING;
                  blink <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a seconds-level model.
module tb_alarm_trigger;
   localparam int RING = 30;
   localparam int SNZ  = 10;
   localparam int MAXS = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sec_tick = 1'b0;
   logic        alarm_en = 1'b0;
   logic        set_mode = 1'b0;
   logic        push_c = 1'b0;
   logic        push_u = 1'b0;
   logic [15:0] time_now = 16'h0100;
   logic [15:0] alarm = 16'h0105;
   logic        ringing;
   logic        missed;
   logic [15:0] led;
   logic [1:0]  state;

   alarm_trigger #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
      .clk      (clk),
      .reset    (reset),
      .sec_tick (sec_tick),
      .time_now (time_now),
      .alarm    (alarm),
      .alarm_en (alarm_en),
      .set_mode (set_mode),
      .push_c   (push_c),
      .push_u   (push_u),
      .ringing  (ringing),
      .led      (led),
      .missed   (missed),
      .state    (state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   // m_* is what the outputs must show now; n_* what they must show after the next edge.
   int m_st = 0, m_rem = 0, m_snz = 0;
   bit m_blink = 0, m_mq = 0, m_missed = 0, m_ring = 0;
   logic [15:0] m_led = '0;
   int n_st = 0, n_rem = 0, n_snz = 0;
   bit n_blink = 0, n_mq = 0, n_missed = 0, n_ring = 0;
   logic [15:0] n_led = '0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] led_of(input int st, input bit b, input int n);
      if (st == 2) return b ? 16'hFFFF : 16'h0000;
      if (st == 3) return 16'((1 << ((n > 3) ? 3 : n)) - 1);
      return 16'h0000;
   endfunction

   task automatic model_step();
      bit match, fire, dis;
      n_st = m_st; n_rem = m_rem; n_snz = m_snz;
      n_blink = m_blink; n_missed = m_missed;
      if (reset) begin
         n_st = 0; n_rem = 0; n_snz = 0; n_blink = 0; n_mq = 0;
         n_missed = 0; n_ring = 0; n_led = '0;
         return;
      end
      match  = (time_now == alarm);
      fire   = match && !m_mq && !set_mode;
      dis    = push_c || set_mode;
      n_mq   = match;
      n_ring = (m_st == 2);
      n_led  = led_of(m_st, m_blink, m_snz);
      if (push_c) n_missed = 0;
      case (m_st)
         0: if (alarm_en) n_st = 1;
         1: begin
            if (!alarm_en) n_st = 0;
            else if (fire) begin n_st = 2; n_rem = RING; n_blink = 1; n_snz = 0; end
         end
         2: begin
            if (!alarm_en) n_st = 0;
            else if (dis) begin n_st = 1; n_missed = 0; end
            else if (push_u && m_snz < MAXS) begin n_st = 3; n_rem = SNZ; n_snz = m_snz + 1; end
            else if (sec_tick) begin
               if (m_rem == 1) begin n_st = 1; n_missed = 1; end
               else begin n_rem = m_rem - 1; n_blink = !m_blink; end
            end
         end
         default: begin
            if (!alarm_en) n_st = 0;
            else if (dis) n_st = 1;
            else if (sec_tick) begin
               if (m_rem == 1) begin n_st = 2; n_rem = RING; n_blink = 1; end
               else n_rem = m_rem - 1;
            end
         end
      endcase
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      m_st = n_st; m_rem = n_rem; m_snz = n_snz; m_blink = n_blink;
      m_mq = n_mq; m_missed = n_missed; m_ring = n_ring; m_led = n_led;
      sec_tick = 1'b0;
      push_c   = 1'b0;
      push_u   = 1'b0;
   endtask

   task automatic tick_at(input logic [15:0] t);
      time_now = t;
      sec_tick = 1'b1;
      cyc();
   endtask

   task automatic run_ticks(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         tick_at(base + 16'(i));
         cyc();
      end
   endtask

   task automatic start_ring();
      tick_at(16'h0104);
      cyc();
      tick_at(16'h0105);
      cyc();
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("state", 16'(state), 16'(m_st));
         chk("ringing", 16'(ringing), 16'(m_ring));
         chk("led", led, m_led);
         chk("missed", 16'(missed), 16'(m_missed));
      end
   end

   initial begin
      int r;
      cyc();
      cmp_en = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_state", 16'(state), 16'd0);
      chk("rst_ringing", 16'(ringing), 16'd0);
      chk("rst_led", led, 16'h0000);
      chk("rst_missed", 16'(missed), 16'd0);

      // Basic ring with two-cycle latency and blinking
      alarm_en = 1'b1;
      cyc();
      chk("arm", 16'(state), 16'd1);
      tick_at(16'h0104);
      cyc();
      tick_at(16'h0105);
      chk("lat1_ringing", 16'(ringing), 16'd0);
      cyc();
      chk("lat2_ringing", 16'(ringing), 16'd1);
      chk("blink_on", led, 16'hFFFF);
      tick_at(16'h0106);
      cyc();
      chk("blink_off", led, 16'h0000);
      tick_at(16'h0107);
      cyc();
      chk("blink_on2", led, 16'hFFFF);
      push_c = 1'b1;
      cyc();
      chk("dismiss_state", 16'(state), 16'd1);
      cyc();
      chk("dismiss_ringing", 16'(ringing), 16'd0);

      // Ring timeout
      start_ring();
      run_ticks(RING - 1, 16'h0200);
      chk("pre_timeout", 16'(state), 16'd2);
      tick_at(16'h0300);
      chk("timeout_state", 16'(state), 16'd1);
      chk("timeout_missed", 16'(missed), 16'd1);
      cyc();
      chk("timeout_ringing", 16'(ringing), 16'd0);
      push_c = 1'b1;
      cyc();
      chk("missed_clear", 16'(missed), 16'd0);

      // Snooze limit
      start_ring();
      push_u = 1'b1;
      cyc();
      cyc();
      chk("snz1_led", led, 16'h0001);
      chk("snz1_ringing", 16'(ringing), 16'd0);
      run_ticks(SNZ, 16'h0400);
      chk("rering1", 16'(state), 16'd2);
      push_u = 1'b1;
      cyc();
      cyc();
      chk("snz2_led", led, 16'h0003);
      run_ticks(SNZ, 16'h0420);
      push_u = 1'b1;
      cyc();
      cyc();
      chk("snz3_led", led, 16'h0007);
      run_ticks(SNZ, 16'h0440);
      chk("rering3", 16'(state), 16'd2);
      push_u = 1'b1;
      cyc();
      chk("snz4_ignored", 16'(state), 16'd2);
      cyc();
      chk("snz4_ringing", 16'(ringing), 16'd1);
      push_c = 1'b1;
      push_u = 1'b1;
      cyc();
      chk("c_and_u", 16'(state), 16'd1);

      // set_mode inhibits triggering
      tick_at(16'h0104);
      cyc();
      set_mode = 1'b1;
      tick_at(16'h0105);
      set_mode = 1'b0;
      cyc();
      cyc();
      chk("setmode_state", 16'(state), 16'd1);
      chk("setmode_ringing", 16'(ringing), 16'd0);

      // Disarm mid-ring
      start_ring();
      alarm_en = 1'b0;
      cyc();
      chk("disarm_state", 16'(state), 16'd0);
      cyc();
      chk("disarm_led", led, 16'h0000);
      alarm_en = 1'b1;
      cyc();

      // No re-fire within the same matching second
      tick_at(16'h0104);
      cyc();
      tick_at(16'h0105);
      push_c = 1'b1;
      cyc();
      repeat (5) cyc();
      chk("no_refire", 16'(state), 16'd1);
      tick_at(16'h0106);
      cyc();
      tick_at(16'h0105);
      chk("refire_next", 16'(state), 16'd2);

      // Reset while snoozing
      push_u = 1'b1;
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_snz_state", 16'(state), 16'd0);
      chk("rst_snz_led", led, 16'h0000);
      chk("rst_snz_ringing", 16'(ringing), 16'd0);
      cyc();
      chk("rst_rearm", 16'(state), 16'd1);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            r = int'($urandom_range(0, 2));
            alarm = (r == 0) ? 16'h0105 : (r == 1) ? 16'h0000 : 16'($urandom_range(0, 65535));
         end
         reset = ($urandom_range(0, 799) == 0);
         if ($urandom_range(0, 299) == 0) alarm_en = !alarm_en;
         if ($urandom_range(0, 149) == 0) set_mode = !set_mode;
         push_c = ($urandom_range(0, 59) == 0);
         push_u = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) begin
            sec_tick = 1'b1;
            r = int'($urandom_range(0, 3));
            if (r < 2) time_now = alarm;
            else if (r == 2) time_now = alarm + 16'd1;
            else time_now = 16'($urandom_range(0, 65535));
         end
         cyc();
      end
      reset = 1'b0;
      cyc();
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
